// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_pkg
//  Description : Shared scalar and register-address types for the core.
//  Revision    : 1.0
// ============================================================================
package common_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;

    localparam int CREG_AW = 5;
    typedef logic [CREG_AW-1:0] creg_addr_t;

endpackage : common_pkg
`default_nettype wire

// File: rtl/pipes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipes_pkg
//  Description : Pipeline forwarding constants and scoreboard entry type.
//  Revision    : 1.0
// ============================================================================
package pipes_pkg;
    import common_pkg::*;

    localparam int FWD_SEL_RF = 0;
    localparam int SB_LATW    = 3;

    typedef struct packed {
        u1                  pend;
        logic [SB_LATW-1:0] cnt;
    } scoreboard_entry_t;

endpackage : pipes_pkg
`default_nettype wire

// File: rtl/fwd_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_prio_enc
//  Description : Youngest-first forwarding match for one source operand.
//  Revision    : 1.0
// ============================================================================
module fwd_prio_enc
    import common_pkg::*;
    import pipes_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  logic [AW-1:0]        src,
    input  logic [NSTAGE-1:0]    stage_valid,
    input  logic [NSTAGE-1:0]    stage_wen,
    input  logic [NSTAGE*AW-1:0] stage_rd,
    input  logic [NSTAGE-1:0]    stage_ready,
    output logic [SELW-1:0]      sel,
    output logic                 hazard
);

    u1 w_found;

    // The first match decides; a not-ready young producer must never be
    // bypassed by an older stage holding a stale value.
    always_comb begin
        w_found = 1'b0;
        sel     = SELW'(FWD_SEL_RF);
        hazard  = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!w_found && stage_valid[i] && stage_wen[i] &&
                (stage_rd[i*AW +: AW] == src) && (src != '0)) begin
                w_found = 1'b1;
                if (stage_ready[i]) begin
                    sel = SELW'(i + 1);
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule : fwd_prio_enc
`default_nettype wire

// File: rtl/bypass_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_scoreboard
//  Description : Operand bypass selection, multi-cycle scoreboard and stall.
//  Revision    : 1.0
// ============================================================================
module bypass_scoreboard
    import common_pkg::*;
    import pipes_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int NSTAGE = 3,
    parameter int LATW   = SB_LATW,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSTAGE-1:0]    stage_valid,
    input  logic [NSTAGE-1:0]    stage_wen,
    input  logic [NSTAGE*AW-1:0] stage_rd,
    input  logic [NSTAGE-1:0]    stage_ready,
    input  logic                 issue_fire,
    input  logic                 issue_wen,
    input  logic [AW-1:0]        issue_rd,
    input  logic [LATW-1:0]      issue_lat,
    input  logic                 wb_commit,
    input  logic [AW-1:0]        wb_rd,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic [NREG-1:0]      pend_vec,
    output logic [63:0]          stall_cycles
);

    scoreboard_entry_t r_sb [NREG];
    u64                r_stall_cycles;

    logic [NSRC-1:0] w_stage_haz;
    logic [NSRC-1:0] w_sb_haz;
    u1               w_issue_eff;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [AW-1:0] w_src;
        assign w_src = src_addr[s*AW +: AW];

        fwd_prio_enc #(
            .NSTAGE (NSTAGE),
            .AW     (AW),
            .SELW   (SELW)
        ) u_enc (
            .src         (w_src),
            .stage_valid (stage_valid),
            .stage_wen   (stage_wen),
            .stage_rd    (stage_rd),
            .stage_ready (stage_ready),
            .sel         (fwd_sel[s*SELW +: SELW]),
            .hazard      (w_stage_haz[s])
        );

        // A pending register whose countdown has expired sits in a stage
        // and is covered by forwarding.
        assign w_sb_haz[s] = (w_src != '0) && r_sb[w_src].pend &&
                             (r_sb[w_src].cnt != '0);
    end

    assign stall        = (|(w_stage_haz | w_sb_haz)) && !flush;
    assign w_issue_eff  = issue_fire && !stall && !flush;
    assign stall_cycles = r_stall_cycles;

    always_comb begin
        pend_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            pend_vec[r] = r_sb[r].pend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_sb[r] <= '0;
            end
            r_stall_cycles <= '0;
        end else begin
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 64'd1;
            end
            if (flush) begin
                for (int r = 0; r < NREG; r++) begin
                    r_sb[r] <= '0;
                end
            end else begin
                for (int r = 0; r < NREG; r++) begin
                    if (r_sb[r].cnt != '0) begin
                        r_sb[r].cnt <= r_sb[r].cnt - SB_LATW'(1);
                    end
                end
                if (wb_commit && (wb_rd != '0)) begin
                    r_sb[wb_rd].pend <= 1'b0;
                end
                // Later assignment lets a same-register issue override the retire.
                if (w_issue_eff && issue_wen && (issue_rd != '0)) begin
                    r_sb[issue_rd].pend <= 1'b1;
                    r_sb[issue_rd].cnt  <= SB_LATW'(issue_lat);
                end
            end
        end
    end

endmodule : bypass_scoreboard
`default_nettype wire
